mem_arbiter: RTL

- Arbitrates the single embedded data/instruction memory between two requesters: IFU (read-only) and LSU (read/write, byte-sized).
- Sits between the fetch/load-store units and the memory port.
- Sequences each access through a small FSM with a fixed memory latency.
- Exactly one transaction is outstanding at a time.

---
 rtl/mem_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: IFU fetches and LSU loads/stores share one memory.
// One transaction in flight; LSU favoured unless the IFU has been starved.
module mem_arbiter #(
  parameter int DATA_W     = 64,
  parameter int BYT_W      = 8,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              iClock,
  input  logic              iReset,
  input  logic              pIfu_iReq,
  input  logic [DATA_W-1:0] pIfu_iAddr,
  output logic              pIfu_oGnt,
  output logic              pIfu_oRspVld,
  input  logic              pLsu_iReq,
  input  logic              pLsu_iWrEn,
  input  logic [DATA_W-1:0] pLsu_iAddr,
  input  logic [DATA_W-1:0] pLsu_iWrData,
  input  logic [BYT_W-1:0]  pLsu_iWrByt,
  output logic              pLsu_oGnt,
  output logic              pLsu_oRspVld,
  output logic [DATA_W-1:0] pArb_oRdData,
  output logic              pMem_oRdEn,
  output logic              pMem_oWrEn,
  output logic [DATA_W-1:0] pMem_oAddr,
  output logic [DATA_W-1:0] pMem_oWrData,
  output logic [BYT_W-1:0]  pMem_oWrByt,
  input  logic [DATA_W-1:0] pMem_iRdData
);

  localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t        state;
  logic [LW-1:0] lat_cnt;
  logic [SW-1:0] starve_cnt;
  logic          src_lsu;
  logic          we;
  logic          starved;
  logic          ifu_win;
  logic          lsu_win;
  logic          we_next;

  assign starved = (starve_cnt >= SW'(STARVE_MAX));

  // Grant is combinational so the requester sees acceptance this cycle.
  always_comb begin
    ifu_win = 1'b0;
    lsu_win = 1'b0;
    if (state == IDLE && !iReset) begin
      if (pLsu_iReq && !(pIfu_iReq && starved))
        lsu_win = 1'b1;
      else if (pIfu_iReq)
        ifu_win = 1'b1;
    end
  end

  assign pIfu_oGnt = ifu_win;
  assign pLsu_oGnt = lsu_win;
  assign we_next   = lsu_win & pLsu_iWrEn;

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state        <= IDLE;
      lat_cnt      <= '0;
      starve_cnt   <= '0;
      src_lsu      <= 1'b0;
      we           <= 1'b0;
      pIfu_oRspVld <= 1'b0;
      pLsu_oRspVld <= 1'b0;
      pArb_oRdData <= '0;
      pMem_oRdEn   <= 1'b0;
      pMem_oWrEn   <= 1'b0;
      pMem_oAddr   <= '0;
      pMem_oWrData <= '0;
      pMem_oWrByt  <= '0;
    end else begin
      pIfu_oRspVld <= 1'b0;
      pLsu_oRspVld <= 1'b0;
      pMem_oWrEn   <= 1'b0;
      case (state)
        IDLE: begin
          if (ifu_win || lsu_win) begin
            state        <= ACCESS;
            src_lsu      <= lsu_win;
            we           <= we_next;
            lat_cnt      <= LW'(MEM_LAT - 1);
            pMem_oRdEn   <= ~we_next;
            pMem_oWrEn   <= we_next;
            pMem_oAddr   <= lsu_win ? pLsu_iAddr : pIfu_iAddr;
            pMem_oWrData <= lsu_win ? pLsu_iWrData : '0;
            pMem_oWrByt  <= lsu_win ? pLsu_iWrByt : '0;
            if (ifu_win)
              starve_cnt <= '0;
            else if (pIfu_iReq && !starved)
              starve_cnt <= starve_cnt + 1'b1;
          end
        end
        ACCESS: begin
          if (lat_cnt == '0) begin
            state        <= RESP;
            pMem_oRdEn   <= 1'b0;
            pIfu_oRspVld <= ~src_lsu;
            pLsu_oRspVld <= src_lsu;
            if (!we)
              pArb_oRdData <= pMem_iRdData;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
